// File: rtl/ctrl_fsm.sv
// ctrl_fsm -- multi-cycle control unit for a small 9-bit-instruction core.
//
// Walks IDLE -> FETCH -> EXEC -> (MEM -> (WB)) -> FETCH, decoding the fetched
// word held in a 9-bit instruction register (IR). An all-ones BAL (9'h19F)
// parks the unit in HALT until reset.
//
// Handshakes: instr_valid is sampled only while fetch_req is high (FETCH);
// the word on instr is taken on the first rising edge where both are high.
// mem_ready is sampled only while mem_req is high (MEM); the access completes
// on the first rising edge where both are high. Neither side may assume
// anything about the other's signal outside those states.
//
// Ports:
//   clk, rst_n            clock (rising edge), async active-low reset
//   start                 leave IDLE
//   instr, instr_valid    fetched word and its valid strobe
//   alu_eq, alu_lt        ALU flags, evaluated during a branch EXEC cycle
//   mem_ready             memory completion strobe
//   fetch_req             request an instruction (FETCH)
//   mem_req, mem_we       memory access request / write enable (MEM)
//   reg_wr_en             register-file write strobe
//   pc_advance            one pulse per retired instruction
//   reg_a_addr/reg_b_addr register-file read addresses
//   reg_wr_addr           register-file write address
//   alu_op, wb_sel        ALU opcode; write-back source (00 imm,01 mem,10 regA,11 alu)
//   imm                   zero-extended 6-bit immediate
//   branch_take, branch_idx  branch decision and branch LUT index
//   busy, halt            status
//   state_dbg             current FSM state encoding, for debug/checkers
//   instr_count, stall_count  performance counters (CTRL_FSM_PERF_CNT_EN only)
//
// Configuration macro: CTRL_FSM_PERF_CNT_EN adds the saturating performance
// counters and their output ports.

module ctrl_fsm #(
    parameter int DATA_W = 8,
    parameter int RF_AW  = 4,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [8:0]        instr,
    input  logic              instr_valid,
    input  logic              alu_eq,
    input  logic              alu_lt,
    input  logic              mem_ready,
    output logic              fetch_req,
    output logic              mem_req,
    output logic              mem_we,
    output logic              reg_wr_en,
    output logic              pc_advance,
    output logic [RF_AW-1:0]  reg_a_addr,
    output logic [RF_AW-1:0]  reg_b_addr,
    output logic [RF_AW-1:0]  reg_wr_addr,
    output logic [2:0]        alu_op,
    output logic [1:0]        wb_sel,
    output logic [DATA_W-1:0] imm,
    output logic              branch_take,
    output logic [4:0]        branch_idx,
    output logic              busy,
    output logic              halt,
`ifdef CTRL_FSM_PERF_CNT_EN
    output logic [CNT_W-1:0]  instr_count,
    output logic [CNT_W-1:0]  stall_count,
`endif
    output logic [2:0]        state_dbg
);

    if (DATA_W < 6 || RF_AW < 4 || CNT_W < 1) begin : g_bad_params
        $error("ctrl_fsm: needs DATA_W >= 6, RF_AW >= 4, CNT_W >= 1");
    end

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        EXEC  = 3'd2,
        MEM   = 3'd3,
        WB    = 3'd4,
        HALT  = 3'd5
    } state_t;

    localparam logic [1:0] T_I = 2'b00, T_M = 2'b01, T_R = 2'b10, T_B = 2'b11;
    localparam logic [1:0] M_LDR = 2'b00, M_STR = 2'b01, M_MVA = 2'b10, M_MVS = 2'b11;
    localparam logic [1:0] B_BAL = 2'b00, B_BEQ = 2'b01, B_BLT = 2'b10, B_BLE = 2'b11;

    state_t     state;
    logic [8:0] ir;
    logic       pc_adv_q;
    logic       ir_is_halt;
    logic       ir_is_str;
    logic       ir_is_mem;
    logic       str_retire;

    assign ir_is_halt = (ir[8:7] == T_B) && (ir[6:5] == B_BAL) && (ir[4:0] == 5'h1F);
    assign ir_is_str  = (ir[8:7] == T_M) && (ir[6:5] == M_STR);
    assign ir_is_mem  = (ir[8:7] == T_M) && ((ir[6:5] == M_LDR) || (ir[6:5] == M_STR));

    // A store retires in the MEM cycle where mem_ready arrives, so its
    // pc_advance cannot be registered ahead of time; it is ORed in here.
    assign str_retire = (state == MEM) && ir_is_str && mem_ready;
    assign pc_advance = pc_adv_q | str_retire;
    assign state_dbg  = state;

    // Branch flags are only meaningful while the branch is in EXEC, so the
    // decision is formed from the live flags rather than a registered copy.
    always_comb begin
        branch_take = 1'b0;
        if (state == EXEC && ir[8:7] == T_B && !ir_is_halt) begin
            case (ir[6:5])
                B_BAL:   branch_take = 1'b1;
                B_BEQ:   branch_take = alu_eq;
                B_BLT:   branch_take = alu_lt;
                B_BLE:   branch_take = alu_eq | alu_lt;
                default: branch_take = 1'b0;
            endcase
        end
    end

    // Outputs are registered: each transition loads the values belonging to
    // the state being entered. Everything defaults to 0 every cycle, so a
    // field only stays non-zero where it is explicitly re-loaded.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            ir          <= '0;
            fetch_req   <= 1'b0;
            mem_req     <= 1'b0;
            mem_we      <= 1'b0;
            reg_wr_en   <= 1'b0;
            pc_adv_q    <= 1'b0;
            reg_a_addr  <= '0;
            reg_b_addr  <= '0;
            reg_wr_addr <= '0;
            alu_op      <= '0;
            wb_sel      <= '0;
            imm         <= '0;
            branch_idx  <= '0;
            busy        <= 1'b0;
            halt        <= 1'b0;
        end else begin
            fetch_req   <= 1'b0;
            mem_req     <= 1'b0;
            mem_we      <= 1'b0;
            reg_wr_en   <= 1'b0;
            pc_adv_q    <= 1'b0;
            reg_a_addr  <= '0;
            reg_b_addr  <= '0;
            reg_wr_addr <= '0;
            alu_op      <= '0;
            wb_sel      <= '0;
            imm         <= '0;
            branch_idx  <= '0;
            busy        <= 1'b0;
            halt        <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state     <= FETCH;
                        fetch_req <= 1'b1;
                        busy      <= 1'b1;
                    end
                end
                FETCH: begin
                    busy <= 1'b1;
                    if (instr_valid) begin
                        ir    <= instr;
                        state <= EXEC;
                        case (instr[8:7])
                            T_I: begin
                                reg_wr_en   <= 1'b1;
                                reg_wr_addr <= RF_AW'(instr[6]);
                                wb_sel      <= 2'b00;
                                imm         <= DATA_W'(instr[5:0]);
                                pc_adv_q    <= 1'b1;
                            end
                            T_R: begin
                                reg_a_addr  <= RF_AW'(0);
                                reg_b_addr  <= RF_AW'(1);
                                alu_op      <= instr[6:4];
                                reg_wr_addr <= RF_AW'(instr[3:0]);
                                wb_sel      <= 2'b11;
                                reg_wr_en   <= 1'b1;
                                pc_adv_q    <= 1'b1;
                            end
                            T_M: begin
                                case (instr[6:5])
                                    M_LDR: reg_a_addr <= RF_AW'(instr[3:0]);
                                    M_STR: begin
                                        reg_a_addr <= RF_AW'(instr[4]);
                                        reg_b_addr <= RF_AW'(instr[3:0]);
                                    end
                                    M_MVA: begin
                                        reg_a_addr  <= RF_AW'(instr[3:0]);
                                        reg_wr_addr <= RF_AW'(instr[4]);
                                        wb_sel      <= 2'b10;
                                        reg_wr_en   <= 1'b1;
                                        pc_adv_q    <= 1'b1;
                                    end
                                    default: begin // M_MVS
                                        reg_a_addr  <= RF_AW'(instr[4]);
                                        reg_wr_addr <= RF_AW'(instr[3:0]);
                                        wb_sel      <= 2'b10;
                                        reg_wr_en   <= 1'b1;
                                        pc_adv_q    <= 1'b1;
                                    end
                                endcase
                            end
                            default: begin // T_B
                                branch_idx <= instr[4:0];
                                // The halt word does not retire: no pc_advance.
                                if (!(instr[6:5] == B_BAL && instr[4:0] == 5'h1F)) begin
                                    pc_adv_q <= 1'b1;
                                end
                            end
                        endcase
                    end else begin
                        fetch_req <= 1'b1;
                    end
                end
                EXEC: begin
                    if (ir_is_halt) begin
                        state <= HALT;
                        halt  <= 1'b1;
                    end else if (ir_is_mem) begin
                        state      <= MEM;
                        busy       <= 1'b1;
                        mem_req    <= 1'b1;
                        mem_we     <= ir_is_str;
                        reg_a_addr <= reg_a_addr;
                        reg_b_addr <= reg_b_addr;
                    end else begin
                        state     <= FETCH;
                        busy      <= 1'b1;
                        fetch_req <= 1'b1;
                    end
                end
                MEM: begin
                    busy <= 1'b1;
                    if (!mem_ready) begin
                        mem_req    <= 1'b1;
                        mem_we     <= mem_we;
                        reg_a_addr <= reg_a_addr;
                        reg_b_addr <= reg_b_addr;
                    end else if (ir_is_str) begin
                        state     <= FETCH;
                        fetch_req <= 1'b1;
                    end else begin
                        state       <= WB;
                        reg_wr_en   <= 1'b1;
                        wb_sel      <= 2'b01;
                        reg_wr_addr <= RF_AW'(ir[4]);
                        pc_adv_q    <= 1'b1;
                    end
                end
                WB: begin
                    state     <= FETCH;
                    busy      <= 1'b1;
                    fetch_req <= 1'b1;
                end
                HALT: begin
                    halt <= 1'b1;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef CTRL_FSM_PERF_CNT_EN
    // Saturating counters: retired instructions and handshake stall cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_count <= '0;
            stall_count <= '0;
        end else begin
            if (pc_advance && instr_count != {CNT_W{1'b1}}) begin
                instr_count <= instr_count + 1'b1;
            end
            if (((state == FETCH && !instr_valid) || (state == MEM && !mem_ready))
                && stall_count != {CNT_W{1'b1}}) begin
                stall_count <= stall_count + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_ctrl_fsm.sv
// tb_ctrl_fsm -- directed, table-driven bench for ctrl_fsm (default parameters).
// Inputs change on the falling edge; outputs are sampled on the falling edge.

module tb_ctrl_fsm;
    localparam int DATA_W = 8;
    localparam int RF_AW  = 4;
    localparam int CNT_W  = 16;

    localparam logic [2:0] S_IDLE = 3'd0, S_FETCH = 3'd1, S_EXEC = 3'd2,
                           S_MEM = 3'd3, S_WB = 3'd4, S_HALT = 3'd5;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start;
    logic [8:0]        instr;
    logic              instr_valid;
    logic              alu_eq;
    logic              alu_lt;
    logic              mem_ready;
    logic              fetch_req;
    logic              mem_req;
    logic              mem_we;
    logic              reg_wr_en;
    logic              pc_advance;
    logic [RF_AW-1:0]  reg_a_addr;
    logic [RF_AW-1:0]  reg_b_addr;
    logic [RF_AW-1:0]  reg_wr_addr;
    logic [2:0]        alu_op;
    logic [1:0]        wb_sel;
    logic [DATA_W-1:0] imm;
    logic              branch_take;
    logic [4:0]        branch_idx;
    logic              busy;
    logic              halt;
    logic [2:0]        state_dbg;
`ifdef CTRL_FSM_PERF_CNT_EN
    logic [CNT_W-1:0]  instr_count;
    logic [CNT_W-1:0]  stall_count;
`endif

    ctrl_fsm #(.DATA_W(DATA_W), .RF_AW(RF_AW), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .instr(instr),
        .instr_valid(instr_valid), .alu_eq(alu_eq), .alu_lt(alu_lt),
        .mem_ready(mem_ready), .fetch_req(fetch_req), .mem_req(mem_req),
        .mem_we(mem_we), .reg_wr_en(reg_wr_en), .pc_advance(pc_advance),
        .reg_a_addr(reg_a_addr), .reg_b_addr(reg_b_addr),
        .reg_wr_addr(reg_wr_addr), .alu_op(alu_op), .wb_sel(wb_sel),
        .imm(imm), .branch_take(branch_take), .branch_idx(branch_idx),
        .busy(busy), .halt(halt),
`ifdef CTRL_FSM_PERF_CNT_EN
        .instr_count(instr_count), .stall_count(stall_count),
`endif
        .state_dbg(state_dbg)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    // ---------------- observation / scoreboard ----------------
    typedef struct packed {
        logic       fetch_req, mem_req, mem_we, reg_wr_en, pc_advance, branch_take, busy, halt;
        logic [3:0] reg_a, reg_b, reg_wr;
        logic [2:0] alu_op;
        logic [1:0] wb_sel;
        logic [7:0] imm;
        logic [4:0] branch_idx;
    } outs_t;

    typedef struct {
        logic [8:0] instr;
        logic       eq;
        logic       lt;
        outs_t      exp;
        int         lat;
    } vec_t;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    endtask

    function automatic outs_t sample();
        outs_t o;
        o.fetch_req   = fetch_req;
        o.mem_req     = mem_req;
        o.mem_we      = mem_we;
        o.reg_wr_en   = reg_wr_en;
        o.pc_advance  = pc_advance;
        o.branch_take = branch_take;
        o.busy        = busy;
        o.halt        = halt;
        o.reg_a       = reg_a_addr;
        o.reg_b       = reg_b_addr;
        o.reg_wr      = reg_wr_addr;
        o.alu_op      = alu_op;
        o.wb_sel      = wb_sel;
        o.imm         = imm;
        o.branch_idx  = branch_idx;
        return o;
    endfunction

    // Expected outputs of a busy, non-memory cycle.
    function automatic outs_t ex(logic wr_en, logic pc, logic bt, logic [3:0] a, logic [3:0] b,
                                 logic [3:0] wr, logic [2:0] alu, logic [1:0] wb,
                                 logic [7:0] im, logic [4:0] bi);
        outs_t o = '0;
        o.busy = 1'b1;
        o.reg_wr_en = wr_en; o.pc_advance = pc; o.branch_take = bt;
        o.reg_a = a; o.reg_b = b; o.reg_wr = wr; o.alu_op = alu; o.wb_sel = wb;
        o.imm = im; o.branch_idx = bi;
        return o;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic do_reset();
        rst_n = 1'b0;
        start = 1'b0; instr = '0; instr_valid = 1'b0;
        alu_eq = 1'b0; alu_lt = 1'b0; mem_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic go_fetch();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("fetch_entry", {state_dbg, fetch_req, busy}, {S_FETCH, 1'b1, 1'b1});
    endtask

    // ---------------- test ----------------
    vec_t  vecs[16];
    outs_t o_exp;

    initial begin
        vecs[0]  = '{9'h06A, 1'b0, 1'b0, ex(1,1,0, 4'h0,4'h0,4'h1, 3'd0,2'b00, 8'h2A,5'h00), 2};
        vecs[1]  = '{9'h03F, 1'b0, 1'b0, ex(1,1,0, 4'h0,4'h0,4'h0, 3'd0,2'b00, 8'h3F,5'h00), 2};
        vecs[2]  = '{9'h135, 1'b0, 1'b0, ex(1,1,0, 4'h0,4'h1,4'h5, 3'd3,2'b11, 8'h00,5'h00), 2};
        vecs[3]  = '{9'h17F, 1'b0, 1'b0, ex(1,1,0, 4'h0,4'h1,4'hF, 3'd7,2'b11, 8'h00,5'h00), 2};
        vecs[4]  = '{9'h0D6, 1'b0, 1'b0, ex(1,1,0, 4'h6,4'h0,4'h1, 3'd0,2'b10, 8'h00,5'h00), 2};
        vecs[5]  = '{9'h0E9, 1'b0, 1'b0, ex(1,1,0, 4'h0,4'h0,4'h9, 3'd0,2'b10, 8'h00,5'h00), 2};
        vecs[6]  = '{9'h1E7, 1'b0, 1'b1, ex(0,1,1, 4'h0,4'h0,4'h0, 3'd0,2'b00, 8'h00,5'h07), 2};
        vecs[7]  = '{9'h1A3, 1'b0, 1'b1, ex(0,1,0, 4'h0,4'h0,4'h0, 3'd0,2'b00, 8'h00,5'h03), 2};
        vecs[8]  = '{9'h1A3, 1'b1, 1'b0, ex(0,1,1, 4'h0,4'h0,4'h0, 3'd0,2'b00, 8'h00,5'h03), 2};
        vecs[9]  = '{9'h1CA, 1'b0, 1'b1, ex(0,1,1, 4'h0,4'h0,4'h0, 3'd0,2'b00, 8'h00,5'h0A), 2};
        vecs[10] = '{9'h1CA, 1'b1, 1'b0, ex(0,1,0, 4'h0,4'h0,4'h0, 3'd0,2'b00, 8'h00,5'h0A), 2};
        vecs[11] = '{9'h19E, 1'b0, 1'b0, ex(0,1,1, 4'h0,4'h0,4'h0, 3'd0,2'b00, 8'h00,5'h1E), 2};
        vecs[12] = '{9'h1E7, 1'b1, 1'b0, ex(0,1,1, 4'h0,4'h0,4'h0, 3'd0,2'b00, 8'h00,5'h07), 2};
        vecs[13] = '{9'h1E7, 1'b0, 1'b0, ex(0,1,0, 4'h0,4'h0,4'h0, 3'd0,2'b00, 8'h00,5'h07), 2};
        vecs[14] = '{9'h097, 1'b0, 1'b0, ex(0,0,0, 4'h7,4'h0,4'h0, 3'd0,2'b00, 8'h00,5'h00), 4};
        vecs[15] = '{9'h0BC, 1'b0, 1'b0, ex(0,0,0, 4'h1,4'hC,4'h0, 3'd0,2'b00, 8'h00,5'h00), 3};

        // ---- reset state, start required before any strobe ----
        do_reset();
        check("reset_outs", sample(), outs_t'('0));
        check("reset_state", state_dbg, S_IDLE);
`ifdef CTRL_FSM_PERF_CNT_EN
        check("reset_counts", {instr_count, stall_count}, 32'h0);
`endif
        instr = 9'h06A; instr_valid = 1'b1; mem_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("idle_no_start_outs", sample(), outs_t'('0));
        check("idle_no_start_state", state_dbg, S_IDLE);
        instr_valid = 1'b0; mem_ready = 1'b0;

        // ---- FETCH waits indefinitely for instr_valid ----
        go_fetch();
        repeat (3) @(negedge clk);
        check("fetch_stall", {state_dbg, fetch_req, busy, pc_advance}, {S_FETCH, 1'b1, 1'b1, 1'b0});
`ifdef CTRL_FSM_PERF_CNT_EN
        check("fetch_stall_count", stall_count, 16'd3);
`endif

        // ---- table: EXEC-cycle outputs and total latency ----
        do_reset();
        go_fetch();
        mem_ready = 1'b1;
        foreach (vecs[i]) begin
            int cyc;
            instr = vecs[i].instr; instr_valid = 1'b1;
            alu_eq = vecs[i].eq; alu_lt = vecs[i].lt;
            @(negedge clk);
            instr_valid = 1'b0;
            check($sformatf("exec_%0d_outs", i), sample(), vecs[i].exp);
            check($sformatf("exec_%0d_state", i), state_dbg, S_EXEC);
            cyc = 2;
            @(negedge clk);
            while (state_dbg != S_FETCH && cyc < 10) begin
                cyc++;
                @(negedge clk);
            end
            check($sformatf("latency_%0d", i), cyc, vecs[i].lat);
            check($sformatf("back_fetch_%0d", i), {state_dbg, fetch_req}, {S_FETCH, 1'b1});
        end
`ifdef CTRL_FSM_PERF_CNT_EN
        check("table_instr_count", instr_count, 16'd16);
        check("table_stall_count", stall_count, 16'd0);
`endif

        // ---- LDR with mem_ready low for three MEM cycles ----
        do_reset();
        go_fetch();
        begin
            int mem_cnt = 0;
            int pc_seen = 0;
            int we_seen = 0;
            instr = 9'h097; instr_valid = 1'b1; mem_ready = 1'b0;
            @(negedge clk);
            instr_valid = 1'b0;
            for (int k = 0; k < 20; k++) begin
                @(negedge clk);
                if (state_dbg != S_MEM) break;
                if (mem_req) mem_cnt++;
                if (mem_we) we_seen++;
                if (pc_advance) pc_seen++;
                if (mem_cnt == 4) mem_ready = 1'b1;
            end
            check("ldr_mem_req_cycles", mem_cnt, 4);
            check("ldr_no_we", we_seen, 0);
            check("ldr_no_pc_in_mem", pc_seen, 0);
        end
        check("ldr_wb_state", state_dbg, S_WB);
        check("ldr_wb_outs", sample(), ex(1,1,0, 4'h0,4'h0,4'h1, 3'd0,2'b01, 8'h00,5'h00));
`ifdef CTRL_FSM_PERF_CNT_EN
        check("ldr_stall_count", stall_count, 16'd3);
`endif
        @(negedge clk);
        check("ldr_back_fetch", state_dbg, S_FETCH);
`ifdef CTRL_FSM_PERF_CNT_EN
        check("ldr_instr_count", instr_count, 16'd1);
`endif

        // ---- STR retires inside MEM when mem_ready is already high ----
        do_reset();
        go_fetch();
        instr = 9'h0BC; instr_valid = 1'b1; mem_ready = 1'b1;
        @(negedge clk);
        instr_valid = 1'b0;
        @(negedge clk);
        check("str_mem_retire", {state_dbg, mem_req, mem_we, pc_advance}, {S_MEM, 1'b1, 1'b1, 1'b1});
        @(negedge clk);
        check("str_back_fetch", state_dbg, S_FETCH);

        // ---- reset pulsed in the middle of a stalled STR ----
        do_reset();
        go_fetch();
        instr = 9'h06A; instr_valid = 1'b1;
        @(negedge clk);
        instr = 9'h0BC;
        @(negedge clk);
        @(negedge clk);
        instr_valid = 1'b0; mem_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        o_exp = ex(0,0,0, 4'h1,4'hC,4'h0, 3'd0,2'b00, 8'h00,5'h00);
        o_exp.mem_req = 1'b1; o_exp.mem_we = 1'b1;
        check("str_mem_hold_outs", sample(), o_exp);
        check("str_mem_hold_state", state_dbg, S_MEM);
`ifdef CTRL_FSM_PERF_CNT_EN
        check("str_pre_reset_count", instr_count, 16'd1);
`endif
        #2 rst_n = 1'b0;
        #1;
        check("mid_mem_reset_outs", sample(), outs_t'('0));
        check("mid_mem_reset_state", state_dbg, S_IDLE);
`ifdef CTRL_FSM_PERF_CNT_EN
        check("mid_mem_reset_count", instr_count, 16'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;

        // ---- HALT word: no retire, sticky until reset ----
        do_reset();
        go_fetch();
        instr = 9'h19F; instr_valid = 1'b1; alu_eq = 1'b1; alu_lt = 1'b1;
        @(negedge clk);
        check("halt_exec_outs", sample(), ex(0,0,0, 4'h0,4'h0,4'h0, 3'd0,2'b00, 8'h00,5'h1F));
        @(negedge clk);
        o_exp = '0;
        o_exp.halt = 1'b1;
        check("halt_outs", sample(), o_exp);
        check("halt_state", state_dbg, S_HALT);
        start = 1'b1; mem_ready = 1'b1;
        repeat (4) @(negedge clk);
        check("halt_sticky_outs", sample(), o_exp);
        check("halt_sticky_state", state_dbg, S_HALT);
`ifdef CTRL_FSM_PERF_CNT_EN
        check("halt_instr_count", instr_count, 16'd0);
`endif
        do_reset();
        check("halt_reset_state", {state_dbg, halt, busy}, {S_IDLE, 1'b0, 1'b0});

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/ctrl_fsm.md
CTRL_FSM -- requirements
Module: ctrl_fsm

Interface
REQ-001 Parameter DATA_W, default 8, datapath/immediate width (>= 6).
REQ-002 Parameter RF_AW, default 4, register-file address width (>= 4).
REQ-003 Parameter CNT_W, default 16, performance counter width.
REQ-004 Clk  in  1  sole clock, rising edge. Reset_n  in  1  reset, asynchronous, active-low.
REQ-005 start  in  1  leave IDLE. instr  in  9  fetched word. instr_valid  in  1  fetch handshake.
REQ-006 alu_eq, alu_lt  in  1 each  ALU flags. mem_ready  in  1  memory handshake.
REQ-007 fetch_req  out  1. mem_req, mem_we  out  1 each. reg_wr_en  out  1. pc_advance  out  1.
REQ-008 reg_a_addr, reg_b_addr, reg_wr_addr  out  RF_AW each. alu_op  out  3. wb_sel  out  2 (00 imm, 01 mem, 10 regA, 11 alu).
REQ-009 imm  out  DATA_W  zero-extended imm6. branch_take  out  1. branch_idx  out  5  branch LUT index. busy, halt  out  1 each.

Function
REQ-010 Decode from IR: [8:7] type 00 I, 01 M, 10 R, 11 B; M op [6:5] LDR 00, STR 01, MVA 10, MVS 11; B op [6:5] BAL 00, BEQ 01, BLT 10, BLE 11.
REQ-011 States IDLE, FETCH, EXEC, MEM, WB, HALT; IR is a 9-bit register loaded only in FETCH.
REQ-012 IDLE: all strobes 0; start=1 -> FETCH next cycle.
REQ-013 FETCH: fetch_req=1; instr_valid=1 -> load IR, -> EXEC; else hold FETCH indefinitely.
REQ-014 EXEC, I: reg_wr_en=1, reg_wr_addr=IR[6], wb_sel=00, imm=IR[5:0], pc_advance=1, -> FETCH.
REQ-015 EXEC, R: reg_a_addr=0, reg_b_addr=1, alu_op=IR[6:4], reg_wr_addr=IR[3:0], wb_sel=11, reg_wr_en=1, pc_advance=1, -> FETCH.
REQ-016 EXEC, MVA: reg_a_addr=IR[3:0], reg_wr_addr=IR[4]; MVS: reg_a_addr=IR[4], reg_wr_addr=IR[3:0]; both wb_sel=10, reg_wr_en=1, pc_advance=1, -> FETCH.
REQ-017 EXEC, LDR: reg_a_addr=IR[3:0] (address), -> MEM. STR: reg_a_addr=IR[4] (data), reg_b_addr=IR[3:0] (address), -> MEM.
REQ-018 MEM: mem_req=1, mem_we=1 only for STR, register addresses held stable; mem_ready=0 -> stay; STR+mem_ready -> pc_advance=1, -> FETCH; LDR+mem_ready -> WB.
REQ-019 WB: reg_wr_en=1, wb_sel=01, reg_wr_addr=IR[4], pc_advance=1, -> FETCH.
REQ-020 EXEC, B: branch_idx=IR[4:0]; branch_take = 1 (BAL), alu_eq (BEQ), alu_lt (BLT), alu_eq|alu_lt (BLE); pc_advance=1, -> FETCH.
REQ-021 IR=9'b1_1000_0000-style BAL with IR[4:0]=5'h1F is HALT: no branch_take, no pc_advance, -> HALT; HALT exits only by reset.
REQ-022 All strobes (fetch_req, mem_req, mem_we, reg_wr_en, pc_advance, branch_take) are asserted only in the listed state and are 0 otherwise; exactly one pc_advance per retired instruction.
REQ-023 busy=1 in FETCH/EXEC/MEM/WB; halt=1 only in HALT. Unused address outputs default 0.
REQ-024 Latency with instr_valid and mem_ready already high: I/R/MV/B = 2 cycles, STR = 3, LDR = 4.
REQ-025 start ignored outside IDLE; mem_ready/instr_valid ignored outside MEM/FETCH.

Reset
REQ-026 Reset_n low asynchronously forces IDLE, IR=0, all outputs 0, counters 0, including mid-MEM or mid-FETCH.
REQ-027 After Reset_n deasserts, no strobe asserts before start is sampled high.

Configuration
REQ-028 Macro CTRL_FSM_PERF_CNT_EN defined: outputs instr_count and stall_count (CNT_W each); instr_count +1 per pc_advance, stall_count +1 per cycle in FETCH with instr_valid=0 or MEM with mem_ready=0; both saturate at all-ones.
REQ-029 Macro undefined: both ports and counters are absent; all other behaviour identical.

Verification
REQ-030 Reset, start, I instr 9'b0_0_1_101010 with instr_valid=1 -> EXEC cycle: reg_wr_en=1, reg_wr_addr=1, imm=8'h2A, pc_advance=1.
REQ-031 R instr 9'b1_0_011_0101 -> alu_op=3, reg_wr_addr=5, wb_sel=11, back in FETCH after 2 cycles.
REQ-032 LDR 9'b0_1_00_1_0111, mem_ready low 3 cycles -> mem_req high 4 cycles, then WB with reg_wr_addr=1, wb_sel=01; stall_count=3 with macro.
REQ-033 BLE idx 7 with alu_eq=0, alu_lt=1 -> branch_take=1, branch_idx=7; BEQ with alu_eq=0 -> branch_take=0, pc_advance=1.
REQ-034 Reset_n pulsed low during MEM of STR -> mem_req/mem_we drop immediately, state IDLE, instr_count=0.
REQ-035 HALT word 9'h19F -> halt=1, busy=0, no pc_advance; further start/instr_valid have no effect until reset.
